// File: rtl/amoa_8x8_err_meter.sv
// Operand source and error meter for the 8x8-bit approximate multi-operand adder.
// Drives operand sets, tracks the exact sum and accumulates |ED| statistics.
module amoa_8x8_err_meter #(
  parameter int DUT_LAT = 1,
  parameter int CNT_W   = 16,
  parameter int ACC_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             const_mode,
  input  logic [7:0]       const_val,
  input  logic [63:0]      seed,
  output logic [7:0]       x0,
  output logic [7:0]       x1,
  output logic [7:0]       x2,
  output logic [7:0]       x3,
  output logic [7:0]       x4,
  output logic [7:0]       x5,
  output logic [7:0]       x6,
  output logic [7:0]       x7,
  input  logic [10:0]      summ,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] ed_sum,
  output logic [10:0]      ed_max
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  localparam int SW = ((ACC_W > 11) ? ACC_W : 11) + 1;
  localparam logic [SW-1:0] ACC_MAX = SW'({ACC_W{1'b1}});

  state_t           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] issue_q, issue_d;
  logic [CNT_W-1:0] recv_q, recv_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             mode_q, mode_d;
  logic [7:0]       cval_q, cval_d;
  logic [63:0]      lfsr_q, lfsr_d;
  logic [63:0]      x_q, x_d;
  logic             pres_q, pres_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [10:0]      max_q, max_d;

  logic             vld_q [DUT_LAT];
  logic [10:0]      ex_q  [DUT_LAT];

  logic [63:0]      seed_eff;
  logic [63:0]      start_ops;
  logic [10:0]      x_sum;
  logic             cmp_vld;
  logic [10:0]      cmp_ex;
  logic [10:0]      ed;
  logic [SW-1:0]    acc_ext;
  logic [ACC_W-1:0] acc_sat;

  function automatic logic [63:0] lfsr_step(input logic [63:0] l);
    return {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
  endfunction

  assign seed_eff  = (seed == 64'd0) ? 64'h1 : seed;
  assign start_ops = const_mode ? {8{const_val}} : seed_eff;

  always_comb begin
    x_sum = '0;
    for (int i = 0; i < 8; i++) x_sum = x_sum + 11'(x_q[8*i +: 8]);
  end

  // Exact sum travels beside the adder so it lines up with summ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DUT_LAT; i++) begin
        vld_q[i] <= 1'b0;
        ex_q[i]  <= '0;
      end
    end else begin
      vld_q[0] <= pres_q;
      ex_q[0]  <= x_sum;
      for (int i = 1; i < DUT_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        ex_q[i]  <= ex_q[i-1];
      end
    end
  end

  assign cmp_vld = vld_q[DUT_LAT-1];
  assign cmp_ex  = ex_q[DUT_LAT-1];
  assign ed      = (summ >= cmp_ex) ? (summ - cmp_ex) : (cmp_ex - summ);
  assign acc_ext = SW'(sum_q) + SW'(ed);
  assign acc_sat = (acc_ext > ACC_MAX) ? '1 : acc_ext[ACC_W-1:0];

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    issue_d = issue_q;
    recv_d  = recv_q;
    err_d   = err_q;
    mode_d  = mode_q;
    cval_d  = cval_q;
    lfsr_d  = lfsr_q;
    x_d     = '0;
    pres_d  = 1'b0;
    sum_d   = sum_q;
    max_d   = max_q;
    if (cmp_vld) begin
      recv_d = recv_q + 1'b1;
      err_d  = err_q + CNT_W'(ed != 11'd0);
      sum_d  = acc_sat;
      max_d  = (ed > max_q) ? ed : max_q;
    end
    case (state_q)
      IDLE: if (start) begin
        num_d   = num_samples;
        mode_d  = const_mode;
        cval_d  = const_val;
        recv_d  = '0;
        err_d   = '0;
        sum_d   = '0;
        max_d   = '0;
        issue_d = '0;
        lfsr_d  = seed_eff;
        if (num_samples == '0) begin
          state_d = DRAIN;
        end else begin
          x_d     = start_ops;
          pres_d  = 1'b1;
          issue_d = CNT_W'(1);
          if (!const_mode) lfsr_d = lfsr_step(seed_eff);
          state_d = RUN;
        end
      end
      RUN: begin
        if (issue_q == num_q) begin
          state_d = DRAIN;
        end else begin
          x_d     = mode_q ? {8{cval_q}} : lfsr_q;
          pres_d  = 1'b1;
          issue_d = issue_q + 1'b1;
          if (!mode_q) lfsr_d = lfsr_step(lfsr_q);
        end
      end
      DRAIN: if (recv_d == num_q) state_d = FIN;
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      num_q   <= '0;
      issue_q <= '0;
      recv_q  <= '0;
      err_q   <= '0;
      mode_q  <= 1'b0;
      cval_q  <= '0;
      lfsr_q  <= 64'h1;
      x_q     <= '0;
      pres_q  <= 1'b0;
      sum_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
      err_q   <= err_d;
      mode_q  <= mode_d;
      cval_q  <= cval_d;
      lfsr_q  <= lfsr_d;
      x_q     <= x_d;
      pres_q  <= pres_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
    end
  end

  assign {x7, x6, x5, x4, x3, x2, x1, x0} = x_q;
  assign busy    = (state_q == RUN) || (state_q == DRAIN);
  assign done    = (state_q == FIN);
  assign err_cnt = err_q;
  assign ed_sum  = sum_q;
  assign ed_max  = max_q;

endmodule

// File: tb/tb_amoa_8x8_err_meter.sv
// Bench for amoa_8x8_err_meter: a registered adder model closes the loop,
// operand sets and final statistics are scoreboarded.
module tb_amoa_8x8_err_meter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_samples = '0;
  logic        const_mode = 1'b0;
  logic [7:0]  const_val = '0;
  logic [63:0] seed = '0;
  logic [10:0] summ = '0;

  logic [7:0]  x0, x1, x2, x3, x4, x5, x6, x7;
  logic [7:0]  s_x0, s_x1, s_x2, s_x3, s_x4, s_x5, s_x6, s_x7;
  logic        busy, done, s_busy, s_done;
  logic [15:0] err_cnt, s_err;
  logic [31:0] ed_sum;
  logic [3:0]  s_sum;
  logic [10:0] ed_max, s_max;

  int checks = 0;
  int failures = 0;
  int mmode = 0;
  int k = 0;

  typedef struct {
    int     cnt;
    longint sum;
    int     mx;
    int     sat;
  } stat_t;

  stat_t       sq[$];
  logic [63:0] oq[$];

  wire [63:0] xv  = {x7, x6, x5, x4, x3, x2, x1, x0};
  wire [63:0] sxv = {s_x7, s_x6, s_x5, s_x4, s_x3, s_x2, s_x1, s_x0};

  amoa_8x8_err_meter u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .num_samples(num_samples), .const_mode(const_mode),
    .const_val(const_val), .seed(seed),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .x4(x4), .x5(x5), .x6(x6), .x7(x7),
    .summ(summ), .busy(busy), .done(done),
    .err_cnt(err_cnt), .ed_sum(ed_sum), .ed_max(ed_max)
  );

  amoa_8x8_err_meter #(.ACC_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start),
    .num_samples(num_samples), .const_mode(const_mode),
    .const_val(const_val), .seed(seed),
    .x0(s_x0), .x1(s_x1), .x2(s_x2), .x3(s_x3),
    .x4(s_x4), .x5(s_x5), .x6(s_x6), .x7(s_x7),
    .summ(summ), .busy(s_busy), .done(s_done),
    .err_cnt(s_err), .ed_sum(s_sum), .ed_max(s_max)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] exact_of(input logic [63:0] v);
    logic [10:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + 11'(v[8*i +: 8]);
    return s;
  endfunction

  function automatic logic [10:0] model(input int m, input logic [63:0] v,
                                        input int idx);
    logic [10:0] e;
    e = exact_of(v);
    case (m)
      1: return e + 11'd2;
      2: return (idx % 2 == 1) ? 11'd127 : 11'd131;
      3: return e + 11'd7;
      4: return 11'd2040;
      default: return e;
    endcase
  endfunction

  function automatic logic [63:0] step(input logic [63:0] l);
    return {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
  endfunction

  // One-cycle adder model; k numbers the presented samples of a run.
  always @(posedge clk) begin
    summ <= model(mmode, xv, k);
    k    <= start ? 0 : ((xv != 64'd0) ? k + 1 : k);
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input int m, input int n,
                     input bit cm, input logic [7:0] cv,
                     input logic [63:0] sd, input bit restart,
                     input bit sod);
    logic [63:0] l, ops;
    logic [10:0] ex, s;
    stat_t e;
    int ed, dc;
    l = (sd == 64'd0) ? 64'h1 : sd;
    e = '{0, 0, 0, 0};
    for (int i = 0; i < n; i++) begin
      ops = cm ? {8{cv}} : l;
      oq.push_back(ops);
      ex = exact_of(ops);
      s  = model(m, ops, i);
      ed = (s > ex) ? int'(s - ex) : int'(ex - s);
      if (ed != 0) e.cnt++;
      e.sum += ed;
      if (ed > e.mx) e.mx = ed;
      if (!cm) l = step(l);
    end
    e.sat = (e.sum > 15) ? 15 : int'(e.sum);
    sq.push_back(e);
    mmode = m;
    num_samples = 16'(n);
    const_mode = cm;
    const_val = cv;
    seed = sd;
    @(negedge clk);
    start = 1'b1;
    dc = 0;
    for (int c = 1; c <= 400 && dc == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        num_samples = 16'd50;
        seed = ~sd;
        const_val = ~cv;
        const_mode = ~cm;
      end
      if (restart && c == 2) start = 1'b1;
      if (restart && c == 3) start = 1'b0;
      if (xv != 64'd0) begin
        if (oq.size() == 0) check({tag, " extra x"}, xv, 64'd0);
        else check({tag, " x"}, xv, oq.pop_front());
        check({tag, " sat x"}, sxv, xv);
      end
      if (done) dc = c;
    end
    check({tag, " done cycle"}, 64'(dc), 64'(n + 2));
    check({tag, " x left"}, 64'(oq.size()), 64'd0);
    oq.delete();
    e = sq.pop_front();
    check({tag, " err_cnt"}, 64'(err_cnt), 64'(e.cnt));
    check({tag, " ed_sum"}, 64'(ed_sum), 64'(e.sum));
    check({tag, " ed_max"}, 64'(ed_max), 64'(e.mx));
    check({tag, " sat ed_sum"}, 64'(s_sum), 64'(e.sat));
    check({tag, " sat done"}, 64'(s_done), 64'(done));
    if (sod) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, " start on done"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst x", xv, 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst err_cnt", 64'(err_cnt), 64'd0);
    check("rst ed_sum", 64'(ed_sum), 64'd0);
    check("rst ed_max", 64'(ed_max), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run("loopback", 4, 4, 1'b1, 8'hFF, 64'd0, 1'b0, 1'b0);
    run("offset", 1, 100, 1'b0, 8'h00, 64'h0123456789ABCDEF, 1'b0, 1'b0);
    run("mixed", 2, 6, 1'b1, 8'h10, 64'd0, 1'b0, 1'b0);
    run("zero n", 1, 0, 1'b0, 8'h00, 64'h55, 1'b0, 1'b0);
    run("zero seed", 0, 3, 1'b0, 8'h00, 64'd0, 1'b0, 1'b0);
    run("restart", 1, 8, 1'b0, 8'h00, 64'hDEADBEEF00C0FFEE, 1'b1, 1'b1);

    mmode = 1;
    num_samples = 16'd3;
    const_mode = 1'b0;
    seed = 64'hA5A5_0F0F_3C3C_9999;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset err_cnt", 64'(err_cnt), 64'd2);
    rst_n = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort sat busy", 64'(s_busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort err_cnt", 64'(err_cnt), 64'd0);
    check("abort ed_sum", 64'(ed_sum), 64'd0);
    check("abort ed_max", 64'(ed_max), 64'd0);
    check("abort x", xv, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort no done", 64'(done), 64'd0);
    end

    run("after reset", 1, 5, 1'b0, 8'h00, 64'h1357, 1'b0, 1'b0);
    run("saturate", 3, 4, 1'b1, 8'h01, 64'd0, 1'b0, 1'b0);
    check("saturate sat err_cnt", 64'(s_err), 64'd4);
    check("saturate sat ed_max", 64'(s_max), 64'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
